uart_irq_ctrl: RTL

UART_IRQ_CTRL -- requirements
Module: uart_irq_ctrl

---
 rtl/uart_irq_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: per-source level/edge-sticky pending flags, enable
// gating, lowest-index priority encoding and a combined irq with a holdoff window.
module uart_irq_ctrl #(
  parameter int NUM_SRC = 5,
  parameter int CNT_W   = 8,
  parameter int ID_W    = 3
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_SRC-1:0] status_i,
  input  logic [NUM_SRC-1:0] enable_i,
  input  logic [NUM_SRC-1:0] mode_i,
  input  logic [NUM_SRC-1:0] clr_i,
  input  logic [CNT_W-1:0]   holdoff_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] irq_vec_o,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic               irq_id_valid_o,
  output logic [1:0]         state_o
);

  // Handshake note: there is no valid/ready pairing here; clr_i is a one-cycle
  // write-1-to-clear strobe sampled on every rising HCLK edge, and all other
  // inputs are plain synchronous levels.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

  irq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] status_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_d;
  logic [ID_W-1:0]    id_d;
  logic               any_irq;

  assign rise      = status_i & ~status_q;
  assign irq_vec_o = pending_o & enable_i;
  assign any_irq   = |irq_vec_o;
  assign state_o   = state_q;

  // Edge sources keep their flag (set beats clear); level sources simply follow
  // last cycle's status. A level->edge mode switch therefore keeps the flag sticky.
  always_comb begin
    pending_d = (mode_i & ((pending_o & ~clr_i) | rise)) | (~mode_i & status_i);
  end

  // Bit 0 has the highest priority, so scan downward and let the lowest index win.
  always_comb begin
    id_d = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (irq_vec_o[i]) begin
        id_d = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_irq) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!any_irq) begin
          if (holdoff_i != '0) begin
            state_d = HOLDOFF;
            cnt_d   = holdoff_i;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLDOFF: begin
        // holdoff_i is only looked at on entry; the loaded count runs out untouched.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      irq_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_o   <= (state_d == ACTIVE);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      status_q  <= '0;
      pending_o <= '0;
    end else begin
      status_q  <= status_i;
      pending_o <= pending_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_id_o       <= '0;
      irq_id_valid_o <= 1'b0;
    end else begin
      irq_id_valid_o <= any_irq;
      if (any_irq) begin
        irq_id_o <= id_d;
      end
    end
  end

endmodule
